// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: ALU opcodes and result-log entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;

  // Entry layout is {INSTR[3:0], C, B, DATA[DWIDTH-1:0]}
  localparam int INSTR_W     = 4;
  localparam int ENTRY_EXTRA = INSTR_W + 2;

  function automatic int entry_w(input int dw);
    return dw + ENTRY_EXTRA;
  endfunction

  function automatic int instr_lsb(input int dw);
    return dw + 2;
  endfunction

  function automatic int c_pos(input int dw);
    return dw + 1;
  endfunction

  function automatic int b_pos(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/alu_wb_if.sv
// ALU-side and consumer-side signal bundle of the writeback unit.
// Latency: n/a (wiring only).
// Backpressure: RES_VALID/RES_READY handshake on the result log.
interface alu_wb_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                      WE;
  logic [INSTR_W-1:0]        IN_INSTR;
  logic [DWIDTH-1:0]         ALU_OUT;
  logic                      EN_C;
  logic                      EN_B;
  logic                      Cout;
  logic                      Bout;
  logic                      FLAG_CLR;
  logic [DWIDTH-1:0]         ACC;
  logic                      Cin;
  logic                      Bin;
  logic                      Z;
  logic                      RES_VALID;
  logic [DWIDTH+ENTRY_EXTRA-1:0] RES_DATA;
  logic                      RES_READY;
  logic [CW-1:0]             COUNT;
  logic                      OVF;

  // ALU plus result consumer
  modport master (
    output WE, IN_INSTR, ALU_OUT, EN_C, EN_B, Cout, Bout, FLAG_CLR, RES_READY,
    input  ACC, Cin, Bin, Z, RES_VALID, RES_DATA, COUNT, OVF
  );

  // Writeback unit
  modport slave (
    input  WE, IN_INSTR, ALU_OUT, EN_C, EN_B, Cout, Bout, FLAG_CLR, RES_READY,
    output ACC, Cin, Bin, Z, RES_VALID, RES_DATA, COUNT, OVF
  );

endinterface

// File: rtl/res_fifo.sv
// Small result log FIFO with a registered head entry.
// Latency: push-to-vld 1 cycle; next head presented the edge after a pop.
// Backpressure: push refused when full unless a pop happens the same cycle.
module res_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push_req,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic             vld,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_q;
  logic             vld_q;
  logic             push;
  logic             pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign pop    = pop_req && !empty;
  assign push   = push_req && (!full || pop);
  assign rd_nxt = rd_ptr + 1'b1;

  assign vld    = vld_q;
  assign rdata  = head_q;
  assign count  = cnt_q;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    cnt_nxt = cnt_q;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase
  end

  // Storage write; contents need no reset since occupancy guards every read
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      cnt_q <= cnt_nxt;
      vld_q <= (cnt_nxt != '0);
      if (push && empty) begin
        head_q <= wdata;
      end else if (pop) begin
        // Last entry leaving: the head is whatever arrives this cycle, else hold
        if (cnt_q == ONE_CNT) begin
          if (push) head_q <= wdata;
        end else begin
          head_q <= mem[rd_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/alu_wb.sv
// ALU writeback: accumulator, carry/borrow feedback flags, result log.
// Latency: ACC/Z/Cin/Bin 1 cycle after WE; log entry visible 1 cycle after push.
// Backpressure: none toward the ALU; full log drops the entry and sets OVF.
module alu_wb
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic     CLK,
  input  logic     RST_N,
  alu_wb_if.slave  bus
);

  localparam int EW     = entry_w(DWIDTH);
  localparam int I_LSB  = instr_lsb(DWIDTH);
  localparam int C_BIT  = c_pos(DWIDTH);
  localparam int B_BIT  = b_pos(DWIDTH);

  logic [DWIDTH-1:0] acc_q;
  logic              z_q;
  logic              c_q;
  logic              b_q;
  logic              ovf_q;
  logic              c_next;
  logic              b_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dropped;
  logic [EW-1:0]     entry;

  // Flag next-state: an enabled update beats a clear, a clear beats hold
  always_comb begin
    c_next = c_q;
    b_next = b_q;
    if (bus.WE && bus.EN_C)  c_next = bus.Cout;
    else if (bus.FLAG_CLR)   c_next = 1'b0;
    if (bus.WE && bus.EN_B)  b_next = bus.Bout;
    else if (bus.FLAG_CLR)   b_next = 1'b0;
  end

  // Log entry carries the post-update flags
  always_comb begin
    entry                      = '0;
    entry[I_LSB +: INSTR_W]    = bus.IN_INSTR;
    entry[C_BIT]               = c_next;
    entry[B_BIT]               = b_next;
    entry[DWIDTH-1:0]          = bus.ALU_OUT;
  end

  // A strobe is lost only when the log is full and nothing leaves this cycle
  assign dropped = bus.WE && fifo_full && !(bus.RES_READY && !fifo_empty);

  // Accumulator, zero flag, carry/borrow and sticky overflow
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      b_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.WE) begin
        acc_q <= bus.ALU_OUT;
        z_q   <= (bus.ALU_OUT == '0);
      end
      c_q <= c_next;
      b_q <= b_next;
      if (dropped)           ovf_q <= 1'b1;
      else if (bus.FLAG_CLR) ovf_q <= 1'b0;
    end
  end

  res_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push_req (bus.WE),
    .wdata    (entry),
    .pop_req  (bus.RES_READY),
    .vld      (bus.RES_VALID),
    .rdata    (bus.RES_DATA),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (bus.COUNT)
  );

  assign bus.ACC = acc_q;
  assign bus.Z   = z_q;
  assign bus.Cin = c_q;
  assign bus.Bin = b_q;
  assign bus.OVF = ovf_q;

endmodule

// File: tb/tb_alu_wb.sv
// Bench for alu_wb: directed scenarios plus a random run against a scoreboard.
// Latency: n/a.
// Backpressure: RES_READY driven by the scenarios.
module tb_alu_wb;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int DP = 4;

  logic CLK;
  logic RST_N;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_wb_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  alu_wb #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference state: values expected after the coming rising edge
  logic [13:0] q [$];
  logic [7:0]  m_acc;
  logic        m_c, m_b, m_z, m_ovf;

  // Scoreboard: push expected entries as stimulus is applied, check the head
  always @(negedge CLK) begin
    int   sz;
    logic pop, push, cn, bn;
    if (!RST_N) begin
      q.delete();
      m_acc = '0; m_c = 0; m_b = 0; m_z = 0; m_ovf = 0;
    end else begin
      sz = q.size();
      n_cmp++;
      if (bus.RES_VALID !== (sz != 0)) begin
        n_err++;
        $display("FAIL sb_valid: got %b want %b", bus.RES_VALID, (sz != 0));
      end
      if (sz != 0) begin
        n_cmp++;
        if (bus.RES_DATA !== q[0]) begin
          n_err++;
          $display("FAIL sb_head: got %h want %h", bus.RES_DATA, q[0]);
        end
      end
      pop  = bus.RES_READY && (sz != 0);
      push = bus.WE && ((sz < DP) || pop);
      cn = (bus.WE && bus.EN_C) ? bus.Cout : (bus.FLAG_CLR ? 1'b0 : m_c);
      bn = (bus.WE && bus.EN_B) ? bus.Bout : (bus.FLAG_CLR ? 1'b0 : m_b);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({bus.IN_INSTR, cn, bn, bus.ALU_OUT});
      if (bus.WE && !push) m_ovf = 1'b1;
      else if (bus.FLAG_CLR) m_ovf = 1'b0;
      if (bus.WE) begin
        m_acc = bus.ALU_OUT;
        m_z   = (bus.ALU_OUT == 8'h00);
      end
      m_c = cn;
      m_b = bn;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.WE = 0; bus.IN_INSTR = OP_NOP; bus.ALU_OUT = '0; bus.EN_C = 0;
    bus.EN_B = 0; bus.Cout = 0; bus.Bout = 0; bus.FLAG_CLR = 0;
  endtask

  task automatic test_reset;
    RST_N = 0; idle_inputs(); bus.RES_READY = 0;
    bus.WE = 1; bus.ALU_OUT = 8'hAA; bus.IN_INSTR = OP_ADD; bus.EN_C = 1; bus.Cout = 1;
    tick(); tick();
    n_cmp++; if (bus.ACC !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h want 00", bus.ACC); end
    n_cmp++; if ({bus.Cin, bus.Bin, bus.Z} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.Cin, bus.Bin, bus.Z}); end
    n_cmp++; if (bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.RES_VALID); end
    n_cmp++; if (bus.COUNT !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.COUNT); end
    n_cmp++; if (bus.OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.OVF); end
    n_cmp++; if (bus.RES_DATA !== 14'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.RES_DATA); end
  endtask

  task automatic test_add_wrap;
    logic [13:0] exp_e;
    exp_e = {4'h5, 1'b1, 1'b0, 8'h00};
    RST_N = 1; idle_inputs();
    bus.WE = 1; bus.IN_INSTR = OP_ADD; bus.ALU_OUT = 8'h00; bus.EN_C = 1; bus.Cout = 1;
    tick();
    n_cmp++; if (bus.ACC !== 8'h00) begin n_err++; $display("FAIL add_acc: got %h want 00", bus.ACC); end
    n_cmp++; if (bus.Z !== 1'b1) begin n_err++; $display("FAIL add_z: got %b want 1", bus.Z); end
    n_cmp++; if (bus.Cin !== 1'b1) begin n_err++; $display("FAIL add_cin: got %b want 1", bus.Cin); end
    n_cmp++; if (bus.RES_VALID !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", bus.RES_VALID); end
    n_cmp++; if (bus.RES_DATA !== exp_e) begin n_err++; $display("FAIL add_entry: got %h want %h", bus.RES_DATA, exp_e); end
  endtask

  task automatic test_flag_hold;
    logic [13:0] exp_e;
    exp_e = {4'h9, 1'b1, 1'b0, 8'h21};
    idle_inputs();
    bus.WE = 1; bus.IN_INSTR = OP_INC; bus.ALU_OUT = 8'h21; bus.EN_C = 0; bus.Cout = 0;
    tick();
    n_cmp++; if (bus.Cin !== 1'b1) begin n_err++; $display("FAIL hold_cin: got %b want 1", bus.Cin); end
    n_cmp++; if (bus.Z !== 1'b0) begin n_err++; $display("FAIL hold_z: got %b want 0", bus.Z); end
    n_cmp++; if (bus.COUNT !== 3'd2) begin n_err++; $display("FAIL hold_count: got %0d want 2", bus.COUNT); end
    idle_inputs(); bus.RES_READY = 1;
    tick();
    n_cmp++; if (bus.RES_DATA !== exp_e) begin n_err++; $display("FAIL hold_entry: got %h want %h", bus.RES_DATA, exp_e); end
    tick();
    n_cmp++; if (bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL hold_drained: got %b want 0", bus.RES_VALID); end
    bus.RES_READY = 0;
  endtask

  task automatic test_overflow;
    idle_inputs(); bus.RES_READY = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.WE = 1; bus.IN_INSTR = OP_ADD; bus.ALU_OUT = 8'(i);
      tick();
    end
    n_cmp++; if (bus.COUNT !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", bus.COUNT); end
    n_cmp++; if (bus.OVF !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.OVF); end
    n_cmp++; if (bus.ACC !== 8'h05) begin n_err++; $display("FAIL ovf_acc_on_drop: got %h want 05", bus.ACC); end
    idle_inputs(); bus.RES_READY = 1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (bus.RES_VALID !== 1'b1 || bus.RES_DATA[7:0] !== 8'(i)) begin
        n_err++; $display("FAIL ovf_pop%0d: got v=%b d=%h want v=1 d=%h", i, bus.RES_VALID, bus.RES_DATA[7:0], 8'(i));
      end
      tick();
    end
    n_cmp++; if (bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", bus.RES_VALID); end
    bus.RES_READY = 0;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h06};
    idle_inputs(); bus.RES_READY = 0;
    for (int i = 0; i < 4; i++) begin
      bus.WE = 1; bus.IN_INSTR = OP_SUB; bus.ALU_OUT = 8'h10 + 8'(i);
      tick();
    end
    n_cmp++; if (bus.COUNT !== 3'd4) begin n_err++; $display("FAIL fpp_fill: got %0d want 4", bus.COUNT); end
    bus.ALU_OUT = 8'h06; bus.RES_READY = 1;
    tick();
    n_cmp++; if (bus.COUNT !== 3'd4) begin n_err++; $display("FAIL fpp_count: got %0d want 4", bus.COUNT); end
    n_cmp++; if (bus.OVF !== 1'b1) begin n_err++; $display("FAIL fpp_ovf: got %b want 1", bus.OVF); end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.RES_DATA[7:0] !== exp_d[i]) begin
        n_err++; $display("FAIL fpp_order%0d: got %h want %h", i, bus.RES_DATA[7:0], exp_d[i]);
      end
      tick();
    end
    n_cmp++; if (bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b want 0", bus.RES_VALID); end
    bus.RES_READY = 0;
  endtask

  task automatic test_clear_collision;
    idle_inputs();
    n_cmp++; if ({bus.Cin, bus.Bin, bus.OVF} !== 3'b101) begin n_err++; $display("FAIL clr_pre: got %b want 101", {bus.Cin, bus.Bin, bus.OVF}); end
    bus.FLAG_CLR = 1; bus.WE = 1; bus.IN_INSTR = OP_SUB; bus.ALU_OUT = 8'h33;
    bus.EN_B = 1; bus.Bout = 1; bus.EN_C = 0; bus.Cout = 1;
    tick();
    n_cmp++; if ({bus.Cin, bus.Bin, bus.OVF} !== 3'b010) begin n_err++; $display("FAIL clr_collide: got %b want 010", {bus.Cin, bus.Bin, bus.OVF}); end
    n_cmp++; if (bus.ACC !== 8'h33) begin n_err++; $display("FAIL clr_acc: got %h want 33", bus.ACC); end
    idle_inputs(); bus.FLAG_CLR = 1; bus.EN_B = 1; bus.Bout = 1;
    tick();
    n_cmp++; if (bus.Bin !== 1'b0) begin n_err++; $display("FAIL clr_alone_bin: got %b want 0", bus.Bin); end
    n_cmp++; if (bus.ACC !== 8'h33 || bus.COUNT !== 3'd1) begin n_err++; $display("FAIL clr_alone_keep: got acc=%h cnt=%0d want acc=33 cnt=1", bus.ACC, bus.COUNT); end
    idle_inputs(); bus.RES_READY = 1;
    tick();
    bus.RES_READY = 0;
  endtask

  task automatic test_reset_midstream;
    idle_inputs(); bus.RES_READY = 0;
    bus.WE = 1; bus.ALU_OUT = 8'h77; tick(); tick();
    RST_N = 0; tick();
    RST_N = 1;
    n_cmp++; if (bus.COUNT !== 3'd0 || bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL mid_reset: got cnt=%0d v=%b want 0 0", bus.COUNT, bus.RES_VALID); end
    bus.WE = 1; bus.ALU_OUT = 8'h5A; bus.IN_INSTR = OP_DEC; bus.RES_READY = 1;
    tick();
    n_cmp++; if (bus.RES_VALID !== 1'b1 || bus.RES_DATA[7:0] !== 8'h5A || bus.COUNT !== 3'd1) begin
      n_err++; $display("FAIL mid_first: got v=%b d=%h cnt=%0d want 1 5a 1", bus.RES_VALID, bus.RES_DATA[7:0], bus.COUNT);
    end
    idle_inputs(); tick();
    bus.RES_READY = 0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++) begin
      bus.WE       = $urandom_range(0, 3) != 0;
      bus.IN_INSTR = 4'($urandom_range(0, 15));
      bus.ALU_OUT  = 8'($urandom_range(0, 255));
      bus.EN_C     = 1'($urandom_range(0, 1));
      bus.EN_B     = 1'($urandom_range(0, 1));
      bus.Cout     = 1'($urandom_range(0, 1));
      bus.Bout     = 1'($urandom_range(0, 1));
      bus.FLAG_CLR = $urandom_range(0, 7) == 0;
      bus.RES_READY = $urandom_range(0, 2) == 0;
      tick();
      n_cmp++;
      if ({bus.ACC, bus.Cin, bus.Bin, bus.Z, bus.OVF} !== {m_acc, m_c, m_b, m_z, m_ovf} || int'(bus.COUNT) != q.size()) begin
        n_err++;
        $display("FAIL b2b_state%0d: got acc=%h c=%b b=%b z=%b o=%b n=%0d want acc=%h c=%b b=%b z=%b o=%b n=%0d", i,
                 bus.ACC, bus.Cin, bus.Bin, bus.Z, bus.OVF, bus.COUNT, m_acc, m_c, m_b, m_z, m_ovf, q.size());
      end
    end
    idle_inputs(); bus.RES_READY = 1;
    for (int i = 0; i < DP + 1; i++) tick();
    n_cmp++; if (bus.RES_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", bus.RES_VALID); end
    bus.RES_READY = 0;
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_flag_hold();
    test_overflow();
    test_full_push_pop();
    test_clear_collision();
    test_reset_midstream();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
